// File: rtl/phrase_sequencer.sv
// ---------------------------------------------------------------------------
// phrase_sequencer
//
// Playback sequencer for a 16-row phrase. It drives the row index to the
// phrase data registers, waits one cycle for the combinational read to
// settle (FETCH), latches the four channel words plus their gate bits,
// pulses row_strobe, then holds the row for dur base ticks (HOLD) before
// moving on. Each base tick is PRESCALE clk cycles.
//
// Optional feature macro: SEQ_SWING_EN
//   defined   -> odd rows last max(row_ticks,1) + swing_ticks base ticks
//   undefined -> swing_ticks is ignored; every row lasts max(row_ticks,1)
//
// Parameters:
//   PRESCALE        clk cycles per base tick (minimum 1)
//
// Ports:
//   clk             system clock
//   rst_active_low  synchronous active-low reset
//   play_start      pulse: start / restart from row 0
//   play_stop       pulse: stop playback (wins over play_start)
//   loop_en         1 = wrap 15 -> 0, 0 = stop after row 15
//   row_ticks       row duration in base ticks (0 treated as 1)
//   swing_ticks     extra base ticks on odd rows (swing builds only)
//   channel_0..3    phrase words for the current row index
//   row             playback row index
//   playing         high in FETCH or HOLD
//   row_strobe      one-cycle pulse when ch_out_N / gate are updated
//   ch_out_0..3     latched channel words
//   gate            gate[N] = note of ch_out_N is non-zero
// ---------------------------------------------------------------------------
module phrase_sequencer #(
    parameter int PRESCALE = 100000
) (
    input  logic        clk,
    input  logic        rst_active_low,
    input  logic        play_start,
    input  logic        play_stop,
    input  logic        loop_en,
    input  logic [7:0]  row_ticks,
    input  logic [3:0]  swing_ticks,
    input  logic [15:0] channel_0,
    input  logic [15:0] channel_1,
    input  logic [15:0] channel_2,
    input  logic [15:0] channel_3,
    output logic [3:0]  row,
    output logic        playing,
    output logic        row_strobe,
    output logic [15:0] ch_out_0,
    output logic [15:0] ch_out_1,
    output logic [15:0] ch_out_2,
    output logic [15:0] ch_out_3,
    output logic [3:0]  gate
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t        r_state, w_state_next;
    logic [3:0]    r_row, w_row_next;
    logic          r_strobe, w_strobe_next;
    logic [15:0]   r_ch [4];
    logic [15:0]   w_ch_next [4];
    logic [3:0]    r_gate, w_gate_next;
    logic [PW-1:0] r_presc, w_presc_next;
    logic [8:0]    r_tick, w_tick_next;
    logic [8:0]    r_dur, w_dur_next;

    logic [15:0]   w_ch_in [4];
    logic [3:0]    w_new_gate;
    logic [8:0]    w_dur_base;
    logic [8:0]    w_dur_calc;
    logic          w_presc_wrap;
    logic          w_row_done;

    assign w_ch_in[0] = channel_0;
    assign w_ch_in[1] = channel_1;
    assign w_ch_in[2] = channel_2;
    assign w_ch_in[3] = channel_3;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_gate
            assign w_new_gate[gi] = (w_ch_in[gi][15:8] != 8'd0);
        end
    endgenerate

    // Duration of the row being fetched; r_row already points at it.
    assign w_dur_base = (row_ticks == 8'd0) ? 9'd1 : {1'b0, row_ticks};
`ifdef SEQ_SWING_EN
    assign w_dur_calc = w_dur_base + (r_row[0] ? {5'd0, swing_ticks} : 9'd0);
`else
    assign w_dur_calc = w_dur_base;
    logic w_unused_swing;
    assign w_unused_swing = ^swing_ticks;
`endif

    assign w_presc_wrap = (r_presc == PRESC_LAST);
    // The wrap that completes tick number dur ends the row.
    assign w_row_done   = w_presc_wrap && ((r_tick + 9'd1) == r_dur);

    always_comb begin
        w_state_next  = r_state;
        w_row_next    = r_row;
        w_strobe_next = 1'b0;
        w_gate_next   = r_gate;
        w_presc_next  = r_presc;
        w_tick_next   = r_tick;
        w_dur_next    = r_dur;
        for (int i = 0; i < 4; i++) begin
            w_ch_next[i] = r_ch[i];
        end

        case (r_state)
            ST_FETCH: begin
                for (int i = 0; i < 4; i++) begin
                    w_ch_next[i] = w_ch_in[i];
                end
                w_gate_next   = w_new_gate;
                w_strobe_next = 1'b1;
                w_dur_next    = w_dur_calc;
                w_presc_next  = '0;
                w_tick_next   = '0;
                w_state_next  = ST_HOLD;
            end
            ST_HOLD: begin
                if (w_presc_wrap) begin
                    w_presc_next = '0;
                    w_tick_next  = r_tick + 9'd1;
                    if (w_row_done) begin
                        if (r_row == 4'd15 && !loop_en) begin
                            w_state_next = ST_IDLE;
                            w_row_next   = 4'd0;
                            w_gate_next  = 4'd0;
                        end else begin
                            w_row_next   = r_row + 4'd1;
                            w_state_next = ST_FETCH;
                        end
                    end
                end else begin
                    w_presc_next = r_presc + PW'(1);
                end
            end
            default: begin
                // ST_IDLE: outputs hold.
            end
        endcase

        // Start (or restart) overrides normal sequencing.
        if (play_start) begin
            w_state_next = ST_FETCH;
            w_row_next   = 4'd0;
            w_presc_next = '0;
            w_tick_next  = '0;
        end

        // Stop has the last word, so it wins over a simultaneous start.
        if (play_stop) begin
            w_state_next  = ST_IDLE;
            w_row_next    = 4'd0;
            w_gate_next   = 4'd0;
            w_strobe_next = 1'b0;
            for (int i = 0; i < 4; i++) begin
                w_ch_next[i] = 16'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_active_low) begin
            r_state  <= ST_IDLE;
            r_row    <= 4'd0;
            r_strobe <= 1'b0;
            r_gate   <= 4'd0;
            r_presc  <= '0;
            r_tick   <= '0;
            r_dur    <= 9'd1;
            for (int i = 0; i < 4; i++) begin
                r_ch[i] <= 16'd0;
            end
        end else begin
            r_state  <= w_state_next;
            r_row    <= w_row_next;
            r_strobe <= w_strobe_next;
            r_gate   <= w_gate_next;
            r_presc  <= w_presc_next;
            r_tick   <= w_tick_next;
            r_dur    <= w_dur_next;
            for (int i = 0; i < 4; i++) begin
                r_ch[i] <= w_ch_next[i];
            end
        end
    end

    assign row        = r_row;
    assign playing    = (r_state != ST_IDLE);
    assign row_strobe = r_strobe;
    assign ch_out_0   = r_ch[0];
    assign ch_out_1   = r_ch[1];
    assign ch_out_2   = r_ch[2];
    assign ch_out_3   = r_ch[3];
    assign gate       = r_gate;

endmodule

// File: tb/tb_phrase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_phrase_sequencer
//
// Directed bench for phrase_sequencer with PRESCALE = 4. A small phrase
// memory model answers the row index combinationally. A cycle-by-cycle
// vector table covers basic play, stop and start/stop collision; hand
// sequences cover end-of-phrase, loop wrap, restart, mid-row changes,
// reset mid-row and swing timing.
// ---------------------------------------------------------------------------
module tb_phrase_sequencer;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst_active_low = 1'b0;
    logic        play_start = 1'b0;
    logic        play_stop = 1'b0;
    logic        loop_en = 1'b1;
    logic [7:0]  row_ticks = 8'd2;
    logic [3:0]  swing_ticks = 4'd0;
    logic [15:0] channel_0, channel_1, channel_2, channel_3;
    logic [3:0]  row;
    logic        playing;
    logic        row_strobe;
    logic [15:0] ch_out_0, ch_out_1, ch_out_2, ch_out_3;
    logic [3:0]  gate;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    phrase_sequencer #(.PRESCALE(P)) dut (
        .clk            (clk),
        .rst_active_low (rst_active_low),
        .play_start     (play_start),
        .play_stop      (play_stop),
        .loop_en        (loop_en),
        .row_ticks      (row_ticks),
        .swing_ticks    (swing_ticks),
        .channel_0      (channel_0),
        .channel_1      (channel_1),
        .channel_2      (channel_2),
        .channel_3      (channel_3),
        .row            (row),
        .playing        (playing),
        .row_strobe     (row_strobe),
        .ch_out_0       (ch_out_0),
        .ch_out_1       (ch_out_1),
        .ch_out_2       (ch_out_2),
        .ch_out_3       (ch_out_3),
        .gate           (gate)
    );

    // Phrase memory model: channel 3 has a rest (note 0) on odd rows.
    function automatic logic [15:0] ph(input logic [3:0] r, input int n);
        logic [7:0] note;
        note = (n == 3 && r[0]) ? 8'h00 : (8'h3C + {4'h0, r} + 8'(16 * n));
        return {note, 8'h41 + 8'(n)};
    endfunction

    function automatic logic [3:0] exp_gate(input logic [3:0] r);
        return r[0] ? 4'b0111 : 4'b1111;
    endfunction

    assign channel_0 = ph(row, 0);
    assign channel_1 = ph(row, 1);
    assign channel_2 = ph(row, 2);
    assign channel_3 = ph(row, 3);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_active_low = 1'b0;
        play_start = 1'b0;
        play_stop  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_active_low = 1'b1;
    endtask

    task automatic pulse(input logic st, input logic sp);
        @(negedge clk);
        play_start = st;
        play_stop  = sp;
        @(posedge clk);
        #1;
        play_start = 1'b0;
        play_stop  = 1'b0;
    endtask

    // Counts edges until row_strobe is seen after an edge; -1 on timeout.
    task automatic wait_strobe(input int budget, output int n);
        n = -1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk);
            #1;
            if (row_strobe) begin
                n = c;
                break;
            end
        end
        if (n < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL strobe_timeout: got none expected strobe within %0d cycles", budget);
        end
    endtask

    typedef struct {
        logic        start;
        logic        stop;
        logic [7:0]  ticks;
        logic [3:0]  e_row;
        logic        e_play;
        logic        e_strobe;
        logic [15:0] e_ch0;
        logic [3:0]  e_gate;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic sp, input logic [7:0] tk,
                       input logic [3:0] r, input logic pl, input logic sb,
                       input logic [15:0] c0, input logic [3:0] g);
        vec_t v;
        v.start = st; v.stop = sp; v.ticks = tk;
        v.e_row = r; v.e_play = pl; v.e_strobe = sb; v.e_ch0 = c0; v.e_gate = g;
        vecs.push_back(v);
    endtask

    initial begin
        int n;
        int r_seen;
        int cnt;
        int exp_gap;

        // ---- vector table: basic play (row_ticks = 2), stop, collision ----
        add(1, 0, 2, 0, 1, 0, 16'h0000, 4'h0);   // start -> FETCH row 0
        add(0, 0, 2, 0, 1, 1, 16'h3C41, 4'hF);   // strobe, latched row 0
        for (int i = 0; i < 7; i++)
            add(0, 0, 2, 0, 1, 0, 16'h3C41, 4'hF); // HOLD
        add(0, 0, 2, 1, 1, 0, 16'h3C41, 4'hF);   // row 1, FETCH
        add(0, 0, 2, 1, 1, 1, 16'h3D41, 4'h7);   // strobe 9 cycles later
        add(0, 0, 2, 1, 1, 0, 16'h3D41, 4'h7);
        add(0, 1, 2, 0, 0, 0, 16'h0000, 4'h0);   // stop clears outputs
        add(1, 1, 2, 0, 0, 0, 16'h0000, 4'h0);   // start+stop in IDLE: stop wins
        add(1, 0, 2, 0, 1, 0, 16'h0000, 4'h0);   // start again
        add(0, 0, 2, 0, 1, 1, 16'h3C41, 4'hF);

        do_reset();
        chk("reset_row", 32'(row), 32'd0);
        chk("reset_playing", 32'(playing), 32'd0);
        chk("reset_strobe", 32'(row_strobe), 32'd0);
        chk("reset_ch_out", {ch_out_0, ch_out_1 | ch_out_2 | ch_out_3}, 32'd0);
        chk("reset_gate", 32'(gate), 32'd0);

        loop_en = 1'b1;
        foreach (vecs[i]) begin
            @(negedge clk);
            play_start = vecs[i].start;
            play_stop  = vecs[i].stop;
            row_ticks  = vecs[i].ticks;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_row", i), 32'(row), 32'(vecs[i].e_row));
            chk($sformatf("vec%0d_playing", i), 32'(playing), 32'(vecs[i].e_play));
            chk($sformatf("vec%0d_strobe", i), 32'(row_strobe), 32'(vecs[i].e_strobe));
            chk($sformatf("vec%0d_ch0", i), 32'(ch_out_0), 32'(vecs[i].e_ch0));
            chk($sformatf("vec%0d_gate", i), 32'(gate), 32'(vecs[i].e_gate));
            $display("[TB] vec %0d row=%0d playing=%0b strobe=%0b ch0=%h gate=%h",
                     i, row, playing, row_strobe, ch_out_0, gate);
        end
        @(negedge clk);
        play_start = 1'b0;
        play_stop  = 1'b0;

        // ---- end without loop: 16 strobes, 5 cycles apart, then idle ----
        do_reset();
        loop_en   = 1'b0;
        row_ticks = 8'd1;
        pulse(1, 0);
        for (int k = 0; k < 16; k++) begin
            wait_strobe(40, n);
            chk($sformatf("noloop_gap_r%0d", k), 32'(n), (k == 0) ? 32'd1 : 32'd5);
            chk($sformatf("noloop_row_r%0d", k), 32'(row), 32'(k));
            chk($sformatf("noloop_ch3_r%0d", k), 32'(ch_out_3), 32'(ph(4'(k), 3)));
            $display("[TB] noloop strobe row=%0d gap=%0d ch3=%h", row, n, ch_out_3);
        end
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (row_strobe) cnt++;
        end
        chk("noloop_no_17th_strobe", 32'(cnt), 32'd0);
        chk("noloop_playing", 32'(playing), 32'd0);
        chk("noloop_row", 32'(row), 32'd0);
        chk("noloop_gate", 32'(gate), 32'd0);
        $display("[TB] noloop end playing=%0b row=%0d gate=%h", playing, row, gate);

        // ---- loop wrap: row 15 -> 0 with strobe, playing stays high ----
        do_reset();
        loop_en = 1'b1;
        pulse(1, 0);
        for (int k = 0; k < 16; k++) wait_strobe(40, n);
        chk("loop_last_row", 32'(row), 32'd15);
        wait_strobe(40, n);
        chk("loop_wrap_gap", 32'(n), 32'd5);
        chk("loop_wrap_row", 32'(row), 32'd0);
        chk("loop_wrap_playing", 32'(playing), 32'd1);
        chk("loop_wrap_gate", 32'(gate), 32'hF);
        $display("[TB] loop wrap row=%0d playing=%0b gap=%0d", row, playing, n);

        // ---- restart during HOLD at row 3 ----
        for (int k = 0; k < 3; k++) wait_strobe(40, n);
        chk("restart_pre_row", 32'(row), 32'd3);
        @(posedge clk);
        pulse(1, 0);
        chk("restart_row", 32'(row), 32'd0);
        chk("restart_playing", 32'(playing), 32'd1);
        wait_strobe(10, n);
        chk("restart_latency", 32'(n), 32'd1);
        chk("restart_ch0", 32'(ch_out_0), 32'h3C41);
        $display("[TB] restart row=%0d ch0=%h latency=%0d", row, ch_out_0, n);

        // ---- start/stop collision in HOLD at row 5 ----
        for (int k = 0; k < 5; k++) wait_strobe(40, n);
        chk("collide_pre_row", 32'(row), 32'd5);
        @(posedge clk);
        pulse(1, 1);
        chk("collide_playing", 32'(playing), 32'd0);
        chk("collide_row", 32'(row), 32'd0);
        chk("collide_ch_out", {ch_out_0 | ch_out_1, ch_out_2 | ch_out_3}, 32'd0);
        chk("collide_gate", 32'(gate), 32'd0);
        chk("collide_strobe", 32'(row_strobe), 32'd0);
        $display("[TB] collision playing=%0b row=%0d gate=%h", playing, row, gate);

        // ---- zero duration and mid-row change of row_ticks ----
        row_ticks = 8'd0;
        pulse(1, 0);
        wait_strobe(10, n);
        wait_strobe(40, n);
        chk("zero_ticks_gap", 32'(n), 32'd5);
        @(negedge clk);
        row_ticks = 8'd1;
        wait_strobe(40, n);
        chk("ticks1_gap", 32'(n), 32'd5);
        @(negedge clk);
        row_ticks = 8'd3;          // changed mid-HOLD
        wait_strobe(40, n);
        chk("midrow_current_gap", 32'(n), 32'd5);
        wait_strobe(40, n);
        chk("midrow_next_gap", 32'(n), 32'd13);
        $display("[TB] mid-row change gaps current=5 next=%0d", n);

        // ---- reset mid-row beats a simultaneous start ----
        @(posedge clk);
        @(negedge clk);
        rst_active_low = 1'b0;
        play_start     = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_playing", 32'(playing), 32'd0);
        chk("midreset_row", 32'(row), 32'd0);
        chk("midreset_ch_out", {ch_out_0 | ch_out_1, ch_out_2 | ch_out_3}, 32'd0);
        chk("midreset_gate", 32'(gate), 32'd0);
        $display("[TB] mid-row reset playing=%0b row=%0d", playing, row);
        @(negedge clk);
        play_start     = 1'b0;
        rst_active_low = 1'b1;

        // ---- swing timing ----
        row_ticks   = 8'd2;
        swing_ticks = 4'd1;
        loop_en     = 1'b1;
        pulse(1, 0);
        wait_strobe(10, n);
        for (int k = 0; k < 4; k++) begin
            r_seen = int'(row);
`ifdef SEQ_SWING_EN
            exp_gap = (r_seen % 2 == 1) ? 13 : 9;
`else
            exp_gap = 9;
`endif
            wait_strobe(40, n);
            chk($sformatf("swing_gap_after_row%0d", r_seen), 32'(n), 32'(exp_gap));
            $display("[TB] swing row %0d -> %0d gap=%0d", r_seen, row, n);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 ns");
        $fatal(1, "watchdog");
    end

endmodule
